// File: rtl/vga_timing_pkg.sv
// Shared defaults for 640x480@60 raster timing and the bundle type carried
// through the sync output delay line.
package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int H_DISPLAY_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_DISPLAY_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  localparam int H_TOTAL      = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL      = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;
  localparam int H_SYNC_START = H_DISPLAY_DEF + H_FRONT_DEF;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF;
  localparam int V_SYNC_START = V_DISPLAY_DEF + V_FRONT_DEF;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic blank_n;
  } sync_bundle_t;

  // Syncs are active-low, so the idle bundle has both syncs high and blanking on.
  localparam sync_bundle_t SYNC_IDLE = '{hsync: 1'b1, vsync: 1'b1, blank_n: 1'b0};

endpackage

// File: rtl/vga_timing_if.sv
// Raster timing outputs: pixel strobe, coordinates, frame marker and the
// delayed sync/blank signals driven towards the DAC.
interface vga_timing_if;
  import vga_timing_pkg::*;

  logic             pixel_tick;
  logic [CNT_W-1:0] current_x;
  logic [CNT_W-1:0] current_y;
  logic             video_on;
  logic             frame_start;
  logic             hsync_o;
  logic             vsync_o;
  logic             blank_n_o;

  modport master (
    output pixel_tick, current_x, current_y, video_on, frame_start,
           hsync_o, vsync_o, blank_n_o
  );

  modport slave (
    input  pixel_tick, current_x, current_y, video_on, frame_start,
           hsync_o, vsync_o, blank_n_o
  );

endinterface

// File: rtl/vga_sync_delay.sv
// Shift register of sync bundles advanced on the pixel strobe, so sync edges
// reach the DAC aligned with pixel data returning from video RAM.
module vga_sync_delay
  import vga_timing_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         shift_en,
  input  sync_bundle_t d,
  output sync_bundle_t q
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst_n, shift_en};
    assign q = d;
  end else begin : g_shift
    sync_bundle_t stages [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        // NOTE: every stage is reset rather than left as uninitialised storage,
        // otherwise stale contents could emit a spurious sync right after reset.
        for (int i = 0; i < DEPTH; i++) stages[i] <= SYNC_IDLE;
      end else if (shift_en) begin
        stages[0] <= d;
        for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
      end
    end

    assign q = stages[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel clock divider, h/v counters, registered coordinate
// stage and a programmable delay on the sync/blank outputs.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int H_DISPLAY  = H_DISPLAY_DEF,
  parameter int H_FRONT    = H_FRONT_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BACK     = H_BACK_DEF,
  parameter int V_DISPLAY  = V_DISPLAY_DEF,
  parameter int V_FRONT    = V_FRONT_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BACK     = V_BACK_DEF,
  parameter int PIPE_DELAY = 2
) (
  input  logic         pclk,
  input  logic         reset,
  vga_timing_if.master vga
);

  localparam int LINE_LEN    = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int FRAME_LINES = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(LINE_LEN - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(FRAME_LINES - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_DISPLAY);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_DISPLAY + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_DISPLAY + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [DIV_W-1:0] div;
  logic             pixel_tick;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic [CNT_W-1:0] current_x;
  logic [CNT_W-1:0] current_y;
  logic             frame_start;
  sync_bundle_t     sync_nxt;
  sync_bundle_t     sync_s;
  sync_bundle_t     sync_d;

  // pixel_tick is registered, so it lags the terminal divider count by one pclk.
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      div        <= '0;
      pixel_tick <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      pixel_tick <= (div == DIV_LAST);
      div        <= (div == DIV_LAST) ? '0 : div + 1'b1;
    end
  end

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pixel_tick) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    // NOTE: default assignment first so no path through this block infers a latch.
    sync_nxt         = SYNC_IDLE;
    sync_nxt.hsync   = !((h_cnt >= HS_START) && (h_cnt < HS_END));
    sync_nxt.vsync   = !((v_cnt >= VS_START) && (v_cnt < VS_END));
    sync_nxt.blank_n = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  end

  // Stage 1 captures the pre-increment counts so coordinates and syncs stay aligned.
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      current_x   <= '0;
      current_y   <= '0;
      sync_s      <= SYNC_IDLE;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pixel_tick && (h_cnt == '0) && (v_cnt == '0);
      if (pixel_tick) begin
        current_x <= h_cnt;
        current_y <= v_cnt;
        sync_s    <= sync_nxt;
      end
    end
  end

  vga_sync_delay #(
    .DEPTH (PIPE_DELAY)
  ) u_sync_delay (
    .clk      (pclk),
    .rst_n    (reset),
    .shift_en (pixel_tick),
    .d        (sync_s),
    .q        (sync_d)
  );

  assign vga.pixel_tick  = pixel_tick;
  assign vga.current_x   = current_x;
  assign vga.current_y   = current_y;
  assign vga.video_on    = sync_s.blank_n;
  assign vga.frame_start = frame_start;
  assign vga.hsync_o     = sync_d.hsync;
  assign vga.vsync_o     = sync_d.vsync;
  assign vga.blank_n_o   = sync_d.blank_n;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: four builds (default, no delay, CLK_DIV=1, tiny
// raster) checked every cycle against an arithmetic model plus vectors and sequences.
module tb_vga_timing_gen;

  typedef struct packed {
    logic       tick;
    logic       fs;
    logic [9:0] x;
    logic [9:0] y;
    logic       vo;
    logic       hs;
    logic       vs;
    logic       bn;
  } obs_t;

  typedef struct {
    int d, n, hd, hf, hs, hb, vd, vf, vs, vb;
  } cfg_t;

  typedef struct {
    int   k;
    obs_t exp;
  } vec_t;

  localparam obs_t RESET_EXP = '{tick: 1'b0, fs: 1'b0, x: 10'd0, y: 10'd0,
                                 vo: 1'b0, hs: 1'b1, vs: 1'b1, bn: 1'b0};

  logic  pclk = 1'b0;
  logic  reset;
  int    k = 0;
  int    n_checks = 0;
  int    n_fail = 0;
  bit    run_chk = 1'b0;
  cfg_t  cfg [4];
  string names [4];
  vec_t  vecs [17];

  always #5 pclk = ~pclk;

  vga_timing_if if_def ();
  vga_timing_if if_p0 ();
  vga_timing_if if_d1 ();
  vga_timing_if if_sm ();

  vga_timing_gen u_def (.pclk(pclk), .reset(reset), .vga(if_def));
  vga_timing_gen #(.PIPE_DELAY(0)) u_p0 (.pclk(pclk), .reset(reset), .vga(if_p0));
  vga_timing_gen #(.CLK_DIV(1), .PIPE_DELAY(3)) u_d1 (.pclk(pclk), .reset(reset), .vga(if_d1));
  vga_timing_gen #(
    .CLK_DIV(3), .PIPE_DELAY(1),
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) u_sm (.pclk(pclk), .reset(reset), .vga(if_sm));

  // pclk edges seen since reset was last released
  always @(posedge pclk or negedge reset) begin
    if (!reset) k <= 0;
    else        k <= k + 1;
  end

  // Reference: the m-th pixel strobe after release lands on edge m*D+1 and loads
  // pixel m-1; the delayed outputs show pixel m-1-PIPE_DELAY.
  function automatic obs_t model(int kk, cfg_t c);
    obs_t r;
    int ht, vt, m, p, q, x, y, qx, qy;
    ht = c.hd + c.hf + c.hs + c.hb;
    vt = c.vd + c.vf + c.vs + c.vb;
    r = RESET_EXP;
    r.tick = (kk >= 1) && (kk % c.d == 0);
    m = (kk >= 1) ? (kk - 1) / c.d : 0;
    if (m >= 1) begin
      p = m - 1;
      x = p % ht;
      y = (p / ht) % vt;
      r.x  = 10'(x);
      r.y  = 10'(y);
      r.vo = (x < c.hd) && (y < c.vd);
      r.fs = ((kk - 1) % c.d == 0) && (x == 0) && (y == 0);
      q = p - c.n;
      if (q >= 0) begin
        qx = q % ht;
        qy = (q / ht) % vt;
        r.hs = !((qx >= c.hd + c.hf) && (qx < c.hd + c.hf + c.hs));
        r.vs = !((qy >= c.vd + c.vf) && (qy < c.vd + c.vf + c.vs));
        r.bn = (qx < c.hd) && (qy < c.vd);
      end
    end
    return r;
  endfunction

  function automatic obs_t sample(int i);
    obs_t r;
    r = RESET_EXP;
    case (i)
      0: r = '{if_def.pixel_tick, if_def.frame_start, if_def.current_x, if_def.current_y,
               if_def.video_on, if_def.hsync_o, if_def.vsync_o, if_def.blank_n_o};
      1: r = '{if_p0.pixel_tick, if_p0.frame_start, if_p0.current_x, if_p0.current_y,
               if_p0.video_on, if_p0.hsync_o, if_p0.vsync_o, if_p0.blank_n_o};
      2: r = '{if_d1.pixel_tick, if_d1.frame_start, if_d1.current_x, if_d1.current_y,
               if_d1.video_on, if_d1.hsync_o, if_d1.vsync_o, if_d1.blank_n_o};
      3: r = '{if_sm.pixel_tick, if_sm.frame_start, if_sm.current_x, if_sm.current_y,
               if_sm.video_on, if_sm.hsync_o, if_sm.vsync_o, if_sm.blank_n_o};
      default: ;
    endcase
    return r;
  endfunction

  function automatic vec_t mk(int kk, int tick, int fs, int x, int y,
                              int vo, int hs, int vs, int bn);
    vec_t v;
    v.k = kk;
    v.exp.tick = (tick != 0);
    v.exp.fs   = (fs != 0);
    v.exp.x    = 10'(x);
    v.exp.y    = 10'(y);
    v.exp.vo   = (vo != 0);
    v.exp.hs   = (hs != 0);
    v.exp.vs   = (vs != 0);
    v.exp.bn   = (bn != 0);
    return v;
  endfunction

  task automatic check_obs(string name, obs_t act, obs_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got tick=%b fs=%b x=%0d y=%0d vo=%b hs=%b vs=%b bn=%b, expected tick=%b fs=%b x=%0d y=%0d vo=%b hs=%b vs=%b bn=%b",
               name, act.tick, act.fs, act.x, act.y, act.vo, act.hs, act.vs, act.bn,
               exp.tick, exp.fs, exp.x, exp.y, exp.vo, exp.hs, exp.vs, exp.bn);
    end
  endtask

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_k(int target);
    int budget = 50000;
    while (k < target && budget > 0) begin
      @(negedge pclk);
      budget--;
    end
    check($sformatf("reach_cycle_%0d", target), k, target);
  endtask

  // Every cycle, every build against the model.
  always @(negedge pclk) begin
    if (run_chk) begin
      for (int i = 0; i < 4; i++)
        check_obs($sformatf("cycle_%s_k%0d", names[i], k), sample(i), model(k, cfg[i]));
    end
  end

  // Waveform measurements taken between resets.
  int def_hs_low, d1_hs_low, d1_tick_low, sm_vo_cnt, sm_vs_low, def_fs_cnt;
  int def_nf, p0_nf, d1_nf, sm_nfs;
  int def_fall [2], p0_fall [2], d1_fall [2], sm_fs_k [2];
  logic def_prev, p0_prev, d1_prev;

  always @(negedge pclk) begin
    if (!reset) begin
      def_hs_low <= 0; d1_hs_low <= 0; d1_tick_low <= 0; sm_vo_cnt <= 0;
      sm_vs_low <= 0; def_fs_cnt <= 0;
      def_nf <= 0; p0_nf <= 0; d1_nf <= 0; sm_nfs <= 0;
      def_prev <= 1'b1; p0_prev <= 1'b1; d1_prev <= 1'b1;
    end else begin
      if (k >= 1 && k <= 1600 && !if_def.hsync_o) def_hs_low <= def_hs_low + 1;
      if (k >= 1 && k <= 800 && !if_d1.hsync_o) d1_hs_low <= d1_hs_low + 1;
      if (k >= 1 && !if_d1.pixel_tick) d1_tick_low <= d1_tick_low + 1;
      if (if_def.frame_start) def_fs_cnt <= def_fs_cnt + 1;
      if (def_prev && !if_def.hsync_o && def_nf < 2) begin
        def_fall[def_nf] <= k; def_nf <= def_nf + 1;
      end
      if (p0_prev && !if_p0.hsync_o && p0_nf < 2) begin
        p0_fall[p0_nf] <= k; p0_nf <= p0_nf + 1;
      end
      if (d1_prev && !if_d1.hsync_o && d1_nf < 2) begin
        d1_fall[d1_nf] <= k; d1_nf <= d1_nf + 1;
      end
      if (if_sm.frame_start && sm_nfs < 2) begin
        sm_fs_k[sm_nfs] <= k; sm_nfs <= sm_nfs + 1;
      end
      if (sm_nfs + (if_sm.frame_start ? 1 : 0) == 1) begin
        if (if_sm.video_on) sm_vo_cnt <= sm_vo_cnt + 1;
        if (!if_sm.vsync_o) sm_vs_low <= sm_vs_low + 1;
      end
      def_prev <= if_def.hsync_o;
      p0_prev  <= if_p0.hsync_o;
      d1_prev  <= if_d1.hsync_o;
    end
  end

  initial begin
    #900000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: time limit reached at k=%0d", k);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    reset = 1'b0;
    cfg[0] = '{2, 2, 640, 16, 96, 48, 480, 10, 2, 33};
    cfg[1] = '{2, 0, 640, 16, 96, 48, 480, 10, 2, 33};
    cfg[2] = '{1, 3, 640, 16, 96, 48, 480, 10, 2, 33};
    cfg[3] = '{3, 1, 8, 2, 3, 2, 4, 1, 2, 1};
    names[0] = "def"; names[1] = "p0"; names[2] = "d1"; names[3] = "sm";
    //               k    tk fs x    y  vo hs vs bn
    vecs[0]  = mk(0,    0, 0, 0,   0, 0, 1, 1, 0);
    vecs[1]  = mk(1,    0, 0, 0,   0, 0, 1, 1, 0);
    vecs[2]  = mk(2,    1, 0, 0,   0, 0, 1, 1, 0);
    vecs[3]  = mk(3,    0, 1, 0,   0, 1, 1, 1, 0);
    vecs[4]  = mk(4,    1, 0, 0,   0, 1, 1, 1, 0);
    vecs[5]  = mk(5,    0, 0, 1,   0, 1, 1, 1, 0);
    vecs[6]  = mk(7,    0, 0, 2,   0, 1, 1, 1, 1);
    vecs[7]  = mk(1281, 0, 0, 639, 0, 1, 1, 1, 1);
    vecs[8]  = mk(1283, 0, 0, 640, 0, 0, 1, 1, 1);
    vecs[9]  = mk(1287, 0, 0, 642, 0, 0, 1, 1, 0);
    vecs[10] = mk(1317, 0, 0, 657, 0, 0, 1, 1, 0);
    vecs[11] = mk(1319, 0, 0, 658, 0, 0, 0, 1, 0);
    vecs[12] = mk(1509, 0, 0, 753, 0, 0, 0, 1, 0);
    vecs[13] = mk(1511, 0, 0, 754, 0, 0, 1, 1, 0);
    vecs[14] = mk(1601, 0, 0, 799, 0, 0, 1, 1, 0);
    vecs[15] = mk(1603, 0, 1 - 1, 0, 1, 1, 1, 1, 0);
    vecs[16] = mk(1604, 1, 0, 0,   1, 1, 1, 1, 0);
    run_chk = 1'b1;

    // Reset held for 10 cycles, then released on a falling edge.
    repeat (10) @(negedge pclk);
    reset = 1'b1;
    for (int i = 0; i < 17; i++) begin
      wait_k(vecs[i].k);
      check_obs($sformatf("vec%0d_k%0d", i, vecs[i].k), sample(0), vecs[i].exp);
    end

    // Free run: line, sync and frame measurements.
    wait_k(3000);
    check("def_hsync_low_pclk", def_hs_low, 192);
    check("def_line_period", def_fall[1] - def_fall[0], 1600);
    check("delay2_vs_delay0_hsync_edge", def_fall[0] - p0_fall[0], 4);
    check("d1_hsync_low_pclk", d1_hs_low, 96);
    check("d1_line_period", d1_fall[1] - d1_fall[0], 800);
    check("d1_tick_low_cycles", d1_tick_low, 0);
    check("sm_frame_period", sm_fs_k[1] - sm_fs_k[0], 360);
    check("sm_video_on_pclk", sm_vo_cnt, 96);
    check("sm_vsync_low_pclk", sm_vs_low, 90);

    // Asynchronous reset mid-line at x = 300.
    @(negedge pclk);
    reset = 1'b0;
    repeat (2) @(negedge pclk);
    reset = 1'b1;
    wait_k(603);
    check("pre_reset_x", int'(if_def.current_x), 300);
    #2 reset = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) check_obs({"async_reset_", names[i]}, sample(i), RESET_EXP);
    repeat (3) @(negedge pclk);
    reset = 1'b1;
    wait_k(400);
    check("frame_start_once_after_reset", def_fs_cnt, 1);

    // Random reset pulses at random points; the per-cycle model tracks the restarts.
    for (int r = 0; r < 8; r++) begin
      int run_len, dly, hold;
      run_len = int'($urandom_range(20, 1500));
      dly     = int'($urandom_range(1, 3));
      hold    = int'($urandom_range(1, 3));
      repeat (run_len) @(negedge pclk);
      #(dly) reset = 1'b0;
      #1;
      for (int i = 0; i < 4; i++)
        check_obs($sformatf("rand_reset%0d_%s", r, names[i]), sample(i), RESET_EXP);
      repeat (hold) @(negedge pclk);
      reset = 1'b1;
    end
    repeat (200) @(negedge pclk);

    run_chk = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates 640x480@60 Hz VGA raster timing from the system clock and supplies the pixel coordinates (current_x, current_y) to the downstream VGAController, which turns them into image-area and VdRam read addresses.
- Also delays hsync/vsync/blank by a programmable number of pixel periods, so the sync outputs at the DAC line up with pixel data returning from VdRam.
- Issues a frame_start pulse; the zoom FSM uses it to change zoom_level only at frame boundaries.

Parameters:
- CLK_DIV, 2: pclk cycles per pixel (50 MHz to 25 MHz); legal values 1..8.
- H_DISPLAY, 640: visible pixels per line.
- H_FRONT, 16: horizontal front porch, in pixels.
- H_SYNC, 96: hsync pulse width, in pixels.
- H_BACK, 48: horizontal back porch; H_TOTAL = 800.
- V_DISPLAY, 480: visible lines.
- V_FRONT, 10: vertical front porch, in lines.
- V_SYNC, 2: vsync width, in lines.
- V_BACK, 33: vertical back porch; V_TOTAL = 525.
- PIPE_DELAY, 2: pixel periods of delay on hsync_o/vsync_o/blank_n_o; legal values 0..7.

Ports:
- pclk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- pixel_tick  out  1  one-pclk pulse per pixel period.
- current_x  out  10  horizontal count, 0..H_TOTAL-1.
- current_y  out  10  vertical count, 0..V_TOTAL-1.
- video_on  out  1  high when current_x < H_DISPLAY and current_y < V_DISPLAY.
- frame_start  out  1  one-pclk pulse at the start of each frame.
- hsync_o  out  1  active-low hsync, delayed by PIPE_DELAY.
- vsync_o  out  1  active-low vsync, delayed by PIPE_DELAY.
- blank_n_o  out  1  video_on, delayed by PIPE_DELAY.

Behaviour:
- Single clock domain (pclk). Reset is asynchronous, active-low: the reset port is asserted when low.
- Reset values:
  - div counter = 0, h_cnt = 0, v_cnt = 0.
  - pixel_tick = 0, frame_start = 0.
  - current_x = 0, current_y = 0, video_on = 0.
  - hsync_o = 1, vsync_o = 1, blank_n_o = 0.
  - Every delay-line stage = {hsync 1, vsync 1, blank_n 0}.
- Divider:
  - div counts 0..CLK_DIV-1 and wraps.
  - pixel_tick is registered and high for exactly one pclk, in the cycle after div == CLK_DIV-1.
  - With CLK_DIV = 1, pixel_tick is constantly 1 from the first cycle after reset release.
- Counters (stage 0) advance only in cycles where pixel_tick = 1:
  - h_cnt increments; at H_TOTAL-1 it wraps to 0 and v_cnt increments.
  - v_cnt wraps to 0 at V_TOTAL-1, but only together with an h wrap.
- Stage 1 registers, loaded in the same pixel_tick cycle from the pre-increment stage-0 values:
  - current_x = h_cnt, current_y = v_cnt.
  - video_on = (h_cnt < H_DISPLAY) && (v_cnt < V_DISPLAY).
  - hsync_s = ~(h_cnt >= H_DISPLAY+H_FRONT && h_cnt < H_DISPLAY+H_FRONT+H_SYNC), i.e. low for h = 656..751.
  - vsync_s = ~(v_cnt >= V_DISPLAY+V_FRONT && v_cnt < V_DISPLAY+V_FRONT+V_SYNC), i.e. low for v = 490..491.
  - Consequence: x, y, video_on and syncs are mutually aligned and stay constant for CLK_DIV pclk cycles.
- frame_start is high for one pclk, in the cycle after the pixel_tick that loads current_x = 0 and current_y = 0.
  - The first such pulse occurs at the first pixel_tick after reset release.
- Delay line:
  - Holds {hsync_s, vsync_s, video_on} in a PIPE_DELAY-deep shift register.
  - Shifts only on pixel_tick; the outputs are the last stage.
  - PIPE_DELAY = 0: outputs equal the stage-1 values directly (combinational pass-through of registers).
- Widths and arithmetic:
  - All comparisons are unsigned 10-bit; H_TOTAL-1 = 799 and V_TOTAL-1 = 524 both fit.
  - No output ever exceeds H_TOTAL-1 or V_TOTAL-1.
- Reset asserted mid-frame: all state returns to reset values immediately. After release, timing restarts at (0,0) with no partial line or frame.

Decomposition:
- Package vga_timing_pkg holds:
  - the H_*/V_* default localparams and the derived constants H_TOTAL, V_TOTAL, H_SYNC_START, H_SYNC_END, V_SYNC_START, V_SYNC_END;
  - a packed struct sync_bundle_t {hsync, vsync, blank_n} for the delay-line stage type.
- Sub-module vga_sync_delay: a parameterised shift register of sync_bundle_t with a shift enable, reset to the inactive bundle, and a bypass for depth 0.

Test Plan:
- Reset held low 10 cycles, then released, CLK_DIV = 2 -> all outputs at reset values while low. First pixel_tick in pclk cycle 2 after release. frame_start pulses in the following cycle with current_x = 0, current_y = 0, video_on = 1.
- Free-run one line -> pixel_tick period is 2 pclk. hsync low (after PIPE_DELAY) for exactly 96 ticks = 192 pclk. Line period is 1600 pclk. current_x sequences 0..799 and wraps to 0 while current_y increments.
- Free-run 2 frames -> frame_start interval is 800*525*2 = 840000 pclk. vsync low for exactly 2 lines = 3200 pclk. video_on high for 640*480 = 307200 ticks per frame.
- PIPE_DELAY = 2 vs 0 builds compared -> hsync_o, vsync_o and blank_n_o edges occur exactly 2 pixel_ticks (4 pclk) later in the delay-2 build.
- Reset pulsed low mid-line at current_x = 300, current_y = 200 -> outputs return to reset values asynchronously, in the same cycle. After release, the counts restart at (0,0) and frame_start fires once.
- CLK_DIV = 1 build -> pixel_tick constantly high. Line period 800 pclk. hsync_o low for 96 pclk.
